// File: rtl/conv_result_buffer_if.sv
// Stream bundle between the convolution engine, the result buffer and its consumer.
// The buffer uses the slave modport; the engine/consumer side uses master.
interface conv_result_buffer_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_end;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             frame_done;
  logic [CW-1:0]    count;
  logic             full;
  logic             overflow;

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_end,
    input  out_ready,
    output out_data,
    output out_valid,
    output out_last,
    output frame_done,
    output count,
    output full,
    output overflow
  );

  modport master (
    output in_data,
    output in_valid,
    output in_end,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  out_last,
    input  frame_done,
    input  count,
    input  full,
    input  overflow
  );
endinterface

// File: rtl/conv_result_buffer.sv
// FWFT result buffer for the float convolution engine with frame tracking.
// Optional CONV_RELU_EN: clamp negative (non-NaN) words to +0.0 at the write port.
//
// state | meaning
// IDLE  | no frame in progress, FIFO empty
// FILL  | frame in progress, accepting input
// DRAIN | end seen, input dropped, emptying FIFO
// DONE  | one-cycle frame-complete state
module conv_result_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input logic clock,
  input logic rst,
  conv_result_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             full_w;
  logic             out_valid_w;
  logic             accepting;
  logic             push;
  logic             pop;
  logic             drop;
  logic [WIDTH-1:0] wr_word;

  function automatic logic [WIDTH-1:0] store_word(input logic [WIDTH-1:0] w);
`ifdef CONV_RELU_EN
    logic is_nan;
    is_nan = (&w[WIDTH-2 -: 8]) && (|w[WIDTH-10:0]);
    if (w[WIDTH-1] && !is_nan) begin
      return '0;
    end
    return w;
`else
    return w;
`endif
  endfunction

  assign full_w      = (count_q == DEPTH_C);
  assign out_valid_w = (count_q != '0);
  assign accepting   = (state_q == IDLE) || (state_q == FILL);
  assign pop         = out_valid_w && bus.out_ready;
  // When full, a same-cycle pop frees the slot the write pointer is aimed at.
  assign push        = bus.in_valid && accepting && (!full_w || pop);
  assign drop        = bus.in_valid && !push;
  assign wr_word     = store_word(bus.in_data);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (push && bus.in_end) begin
          state_d = DRAIN;
        end else if (push) begin
          state_d = FILL;
        end else if (bus.in_end) begin
          state_d = DONE;
        end
      end
      FILL: begin
        if (bus.in_end) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (count_q == '0 || (pop && count_q == ONE_C)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A drop in DONE belongs to the next frame, so it wins over the clear.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (state_q == DONE) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + ONE_C;
        2'b01:   count_q <= count_q - ONE_C;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_word;
    end
  end

  // Gating keeps out_data at zero whenever the FIFO is empty, including reset.
  assign bus.out_data   = out_valid_w ? mem[rd_ptr_q] : '0;
  assign bus.out_valid  = out_valid_w;
  assign bus.out_last   = (state_q == DRAIN) && (count_q == ONE_C);
  assign bus.frame_done = (state_q == DONE);
  assign bus.count      = count_q;
  assign bus.full       = full_w;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_conv_result_buffer.sv
// Directed bench for conv_result_buffer: frames, overflow, full push/pop,
// empty frame, drain drop, ReLU handling and mid-frame reset.
module tb_conv_result_buffer;
  logic clock;
  logic rst;
  int   checks;
  int   errors;

  conv_result_buffer_if #(.DEPTH(16), .WIDTH(32)) bus ();

  conv_result_buffer #(.DEPTH(16), .WIDTH(32)) dut (
    .clock(clock),
    .rst  (rst),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.frame_done !== 1'b0 ||
        bus.full !== 1'b0 || bus.overflow !== 1'b0 || bus.count !== 5'd0 ||
        bus.out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%b last=%b done=%b full=%b ovf=%b count=%0d data=%h, want all zero",
               bus.out_valid, bus.out_last, bus.frame_done, bus.full, bus.overflow, bus.count, bus.out_data);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h3F80_0000;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h3F80_0000) begin
      errors++;
      $display("FAIL basic_w0: valid=%b data=%h, want 1 3f800000", bus.out_valid, bus.out_data);
    end
    bus.in_data = 32'h4000_0000;
    tick();
    checks++;
    if (bus.out_data !== 32'h4000_0000 || bus.count !== 5'd1 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL basic_w1: data=%h count=%0d last=%b, want 40000000 1 0", bus.out_data, bus.count, bus.out_last);
    end
    bus.in_data = 32'h4040_0000;
    bus.in_end  = 1'b1;
    tick();
    checks++;
    if (bus.out_data !== 32'h4040_0000 || bus.out_last !== 1'b1 || bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_w2_last: data=%h last=%b done=%b, want 40400000 1 0", bus.out_data, bus.out_last, bus.frame_done);
    end
    bus.in_valid = 1'b0;
    bus.in_end   = 1'b0;
    tick();
    checks++;
    if (bus.frame_done !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b valid=%b last=%b, want 1 0 0", bus.frame_done, bus.out_valid, bus.out_last);
    end
    tick();
    checks++;
    if (bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width: done=%b, want 0", bus.frame_done);
    end
  endtask

  task automatic test_overflow();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h4100_0000 + 32'(i);
      tick();
      if (i == 15) begin
        checks++;
        if (bus.count !== 5'd16 || bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_full: count=%0d full=%b ovf=%b, want 16 1 0", bus.count, bus.full, bus.overflow);
        end
      end
    end
    checks++;
    if (bus.count !== 5'd16 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop: count=%0d ovf=%b, want 16 1", bus.count, bus.overflow);
    end
    bus.in_valid = 1'b0;
    bus.in_end   = 1'b1;
    tick();
    bus.in_end    = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== (32'h4100_0000 + 32'(i)) ||
          bus.out_last !== (i == 15)) begin
        errors++;
        $display("FAIL ovf_drain[%0d]: valid=%b data=%h last=%b, want 1 %h %b",
                 i, bus.out_valid, bus.out_data, bus.out_last, 32'h4100_0000 + 32'(i), (i == 15));
      end
      tick();
    end
    checks++;
    if (bus.frame_done !== 1'b1 || bus.out_valid !== 1'b0 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_done: done=%b valid=%b ovf=%b, want 1 0 1", bus.frame_done, bus.out_valid, bus.overflow);
    end
    tick();
    checks++;
    if (bus.overflow !== 1'b0 || bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b done=%b, want 0 0", bus.overflow, bus.frame_done);
    end
  endtask

  task automatic test_full_push_pop();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h5000_0000 + 32'(i);
      tick();
    end
    bus.in_data   = 32'h5000_0010;
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.count !== 5'd16 || bus.full !== 1'b1 || bus.overflow !== 1'b0 || bus.out_data !== 32'h5000_0001) begin
      errors++;
      $display("FAIL full_push_pop: count=%0d full=%b ovf=%b data=%h, want 16 1 0 50000001",
               bus.count, bus.full, bus.overflow, bus.out_data);
    end
    bus.in_valid  = 1'b0;
    bus.in_end    = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_end    = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (bus.out_data !== (32'h5000_0000 + 32'(i)) || bus.out_last !== (i == 16)) begin
        errors++;
        $display("FAIL full_drain[%0d]: data=%h last=%b, want %h %b",
                 i, bus.out_data, bus.out_last, 32'h5000_0000 + 32'(i), (i == 16));
      end
      tick();
    end
    checks++;
    if (bus.frame_done !== 1'b1 || bus.count !== 5'd0) begin
      errors++;
      $display("FAIL full_done: done=%b count=%0d, want 1 0", bus.frame_done, bus.count);
    end
    tick();
  endtask

  task automatic test_empty_frame();
    bus.in_end = 1'b1;
    tick();
    checks++;
    if (bus.frame_done !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL empty_done: done=%b valid=%b last=%b, want 1 0 0", bus.frame_done, bus.out_valid, bus.out_last);
    end
    bus.in_end = 1'b0;
    tick();
    checks++;
    if (bus.frame_done !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_after: done=%b valid=%b, want 0 0", bus.frame_done, bus.out_valid);
    end
  endtask

  task automatic test_drain_drop();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h3F00_0000;
    tick();
    bus.in_valid = 1'b0;
    bus.in_end   = 1'b1;
    tick();
    checks++;
    if (bus.out_last !== 1'b1 || bus.count !== 5'd1) begin
      errors++;
      $display("FAIL drop_last: last=%b count=%0d, want 1 1", bus.out_last, bus.count);
    end
    bus.in_end   = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h4500_0000;
    tick();
    checks++;
    if (bus.overflow !== 1'b1 || bus.count !== 5'd1 || bus.out_data !== 32'h3F00_0000) begin
      errors++;
      $display("FAIL drop_word: ovf=%b count=%0d data=%h, want 1 1 3f000000", bus.overflow, bus.count, bus.out_data);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.frame_done !== 1'b1 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL drop_done: done=%b ovf=%b, want 1 1", bus.frame_done, bus.overflow);
    end
    tick();
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL drop_clear: ovf=%b, want 0", bus.overflow);
    end
  endtask

  task automatic test_relu();
    logic [31:0] din [3];
    logic [31:0] exp_w [3];
    din[0] = 32'hC000_0000;
    din[1] = 32'h8000_0000;
    din[2] = 32'hFFC0_0000;
`ifdef CONV_RELU_EN
    exp_w[0] = 32'h0000_0000;
    exp_w[1] = 32'h0000_0000;
`else
    exp_w[0] = 32'hC000_0000;
    exp_w[1] = 32'h8000_0000;
`endif
    exp_w[2] = 32'hFFC0_0000;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = din[i];
      bus.in_end   = (i == 2);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.in_end    = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_w[i] || bus.out_last !== (i == 2)) begin
        errors++;
        $display("FAIL relu[%0d]: valid=%b data=%h last=%b, want 1 %h %b",
                 i, bus.out_valid, bus.out_data, bus.out_last, exp_w[i], (i == 2));
      end
      tick();
    end
    checks++;
    if (bus.frame_done !== 1'b1) begin
      errors++;
      $display("FAIL relu_done: done=%b, want 1", bus.frame_done);
    end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h4200_0000 + 32'(i);
      bus.in_end   = (i == 4);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_end   = 1'b0;
    checks++;
    if (bus.count !== 5'd5 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: count=%0d valid=%b, want 5 1", bus.count, bus.out_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.frame_done !== 1'b0 ||
        bus.full !== 1'b0 || bus.overflow !== 1'b0 || bus.count !== 5'd0 ||
        bus.out_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: valid=%b last=%b done=%b full=%b ovf=%b count=%0d data=%h, want all zero",
               bus.out_valid, bus.out_last, bus.frame_done, bus.full, bus.overflow, bus.count, bus.out_data);
    end
    bus.out_ready = 1'b1;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.frame_done !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_no_done[%0d]: done=%b valid=%b, want 0 0", i, bus.frame_done, bus.out_valid);
      end
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_end    = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic_frame();
    test_overflow();
    test_full_push_pop();
    test_empty_frame();
    test_drain_drop();
    test_relu();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_result_buffer.md
# conv_result_buffer

Downstream stage of the floating-point convolution engine. It takes the engine's 32-bit IEEE-754 result stream (`result`, `out_valid`, `end_conv`) and buffers it in a first-word-fall-through FIFO. It re-emits the words on a valid/ready handshake, marks the final word of each convolution frame, and pulses a frame-complete strobe. This decouples the free-running convolution core from a consumer that may stall.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `WIDTH`, 32: data width; single-precision float.
- `clock`  in  1  system clock; rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_data`  in  WIDTH  convolution result word; connects to the engine's `result`.
- `in_valid`  in  1  `in_data` is valid this cycle; connects to the engine's `out_valid`.
- `in_end`  in  1  end-of-convolution indication; connects to the engine's `end_conv`.
- `out_data`  out  WIDTH  FIFO head word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the word.
- `out_last`  out  1  current head word is the final word of the frame.
- `frame_done`  out  1  one-cycle pulse once the frame is fully drained.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky: at least one input word was dropped in this frame.

## Operation
- State machine with four states:
  - IDLE: no frame in progress and FIFO empty.
  - FILL: frame in progress, accepting input.
  - DRAIN: end seen, no further input accepted.
  - DONE: single-cycle state.
- State transitions:
  - IDLE→FILL on an accepted `in_valid`.
  - IDLE→DONE on `in_end` with no `in_valid`. This is an empty frame: `frame_done` pulses and no `out_last` is produced.
  - FILL→DRAIN on `in_end`. If `in_valid` is also high that cycle, that word is written first (subject to the full rule).
  - DRAIN→DONE on the pop that empties the FIFO. If the FIFO is already empty on entry, DRAIN→DONE on the next cycle.
  - DONE→IDLE unconditionally.
- Push rule: a write happens when `in_valid` is high, state is IDLE or FILL, and the FIFO is not full or a pop happens in the same cycle.
- Drop rule: `in_valid` while full (without a same-cycle pop), or while in DRAIN, drops the word and sets `overflow`.
- Pop rule: a pop happens when `out_valid && out_ready`.
- Occupancy: simultaneous push and pop leaves `count` unchanged.
- `out_valid` = `count != 0`.
- `out_last` = state is DRAIN and `count == 1`.
- `frame_done` is high only in DONE.
- `overflow` clears on DONE→IDLE.
- Pointers wrap modulo DEPTH. `count` never exceeds DEPTH and never underflows.
- `out_data` is held stable while `out_valid && !out_ready`.
- Reset values: all pointers 0, `count`=0, state IDLE. Outputs at reset:
  - `out_valid`=0, `out_last`=0, `frame_done`=0, `full`=0, `overflow`=0.
  - `out_data`=32'h0000_0000.
- Reset asserted mid-frame discards all contents immediately. No `frame_done` is produced for the aborted frame.

## Timing
- Write latency: a word pushed at rising edge N appears on `out_data` with `out_valid`=1 from edge N into cycle N+1, i.e. one-cycle fall-through.
- Throughput: one word per cycle in and out.
- `out_last` becomes visible in the cycle after `in_end` is sampled, if `count == 1` at that point.
- `frame_done` asserts the cycle after the final pop and lasts exactly one cycle.
- A new frame's `in_valid` is accepted in the cycle after DONE (IDLE). `in_valid` during DONE is dropped and counted into the next frame's `overflow`.

## Configuration
- `CONV_RELU_EN` defined: a ReLU is applied at the write port.
  - Any input with sign bit 1 is stored as 32'h0000_0000. This includes -0.0 (32'h8000_0000).
  - NaNs (exponent 8'hFF, mantissa ≠ 0) are stored unchanged.
- `CONV_RELU_EN` undefined: words are stored bit-exact.

## Test plan
- Basic frame: push 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000 on consecutive cycles with `out_ready`=1, then `in_end`.
  - Outputs appear in the same order, each one cycle after its push.
  - `out_last`=1 on 32'h4040_0000.
  - `frame_done` pulses once, one cycle after that pop.
- Overflow: `out_ready`=0, push 17 words 32'h4100_0000 + i.
  - `count`=16 and `full`=1.
  - Word 17 is dropped and `overflow`=1.
  - Draining yields exactly the first 16 words.
- Full with simultaneous push/pop: at `count`=16, `in_valid`=1 and `out_ready`=1 together → word accepted, `count` stays 16, `overflow` stays 0.
- Empty frame and DRAIN drop:
  - `in_end` in IDLE → `frame_done` pulses the next cycle, `out_valid` never rises.
  - `in_valid` during DRAIN → word dropped, `overflow`=1, cleared after DONE.
- ReLU: push 32'hC000_0000, 32'h8000_0000, 32'hFFC0_0000.
  - With `CONV_RELU_EN`: output is 0, 0, 32'hFFC0_0000.
  - Without: the three words are output unchanged.
- Reset mid-drain: assert `rst` low with `count`=5 in DRAIN → all outputs return to their reset values, with no `frame_done` for the aborted frame.
